// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data-memory responder: FSM states,
// RV32I load/store size encodings and byte-lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] carries the access size; every reserved code lands on word.
    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a RAM word and applies RV32I
// sign or zero extension; words and reserved codes pass through.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        data = word;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data RAM responder: stalls the pipeline for LATENCY+1 cycles per
// load/store. Define MISALIGN_TRAP_EN to flag misaligned H/W accesses.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [2:0]            funct3M,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  StallM,
    output logic                  MisalignM
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int ADR_W = IDX_W + 2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADR_W-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]              f3_q, f3_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
    logic                    misalign_q, misalign_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   mem_word;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [DATA_WIDTH-1:0]   wdata_lanes;
    logic [3:0]              be;
    logic                    req, access, flag, mem_we;

    // Address bits above the RAM index wrap away.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ALUResultM[DATA_WIDTH-1:ADR_W];

    assign req      = MemReadM | MemWriteM;
    assign idx      = addr_q[ADR_W-1:2];
    assign mem_word = mem[idx];
    assign access   = (state_q == WAIT) && (cnt_q == '0);
    assign be       = byte_enables(f3_q, addr_q[1:0]);

`ifdef MISALIGN_TRAP_EN
    assign flag = misaligned(f3_q, addr_q[1:0]);
`else
    assign flag = 1'b0;
`endif

    assign mem_we = access && we_q && !flag;

    always_comb begin
        case (f3_q[1:0])
            2'b00:   wdata_lanes = {4{wdata_q[7:0]}};
            2'b01:   wdata_lanes = {2{wdata_q[15:0]}};
            default: wdata_lanes = wdata_q;
        endcase
    end

    load_extend u_load_extend (
        .word   (mem_word),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        we_d        = we_q;
        read_data_d = read_data_q;
        misalign_d  = misalign_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = ALUResultM[ADR_W-1:0];
                    wdata_d = WriteDataM;
                    f3_d    = funct3M;
                    we_d    = MemWriteM;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d    = DONE;
                    misalign_d = flag;
                    if (flag)
                        read_data_d = '0;
                    else if (!we_q)
                        read_data_d = load_data;
                end
            end
            // The request still visible here was already served; never re-issue it.
            default: begin
                state_d    = IDLE;
                misalign_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            read_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            we_q        <= we_d;
            read_data_q <= read_data_d;
            misalign_q  <= misalign_d;
        end
    end

    // NOTE: the RAM array is deliberately not reset so it maps onto memory macros.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    assign StallM    = (state_q == WAIT) || ((state_q == IDLE) && req);
    assign ReadData  = read_data_q;
    assign MisalignM = misalign_q;

endmodule
